mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have the port i_clk, input, 1 bit: the single clock, rising-edge active.
REQ-002 SHALL have the port i_reset, input, 1 bit: synchronous, active-high reset, sampled on the i_clk rising edge.
REQ-003 SHALL have the port i_mem_mem2reg, input, 1 bit: the current instruction is a load.
REQ-004 SHALL have the port i_mem_wmem, input, 1 bit: the current instruction is a store.
REQ-005 SHALL have the port i_mem_wreg, input, 1 bit: the current instruction writes a register.
REQ-006 SHALL have the port i_mem_loadsignext, input, 1 bit: 1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-007 SHALL have the ports i_mem_lsb and i_mem_lsh, input, 1 bit each: byte access and halfword access; both 0 means word access.
REQ-008 SHALL have the port i_data_be, input, 4 bits: store byte enables, precomputed upstream.
REQ-009 SHALL have the port i_mem_rd, input, 5 bits: destination register.
REQ-010 SHALL have the port i_mem_data, input, 32 bits: ALU result, which is the byte address for loads and stores.
REQ-011 SHALL have the port i_mem_dmem, input, 32 bits: raw store data.
REQ-012 SHALL have the ports o_dbus_req and o_dbus_we, output, 1 bit each: data-bus request and write strobe.
REQ-013 SHALL have the ports o_dbus_addr and o_dbus_wdata, output, 32 bits each, and o_dbus_be, output, 4 bits.
REQ-014 SHALL have the ports i_dbus_ack, input, 1 bit, and i_dbus_rdata, input, 32 bits; rdata is valid in the ack cycle.
REQ-015 SHALL have the port o_mem_stall, output, 1 bit: freezes the EXE/MEM register and all earlier stages.
REQ-016 SHALL have the ports o_wb_wreg, output, 1 bit; o_wb_rd, output, 5 bits; and o_wb_data, output, 32 bits: the registered MEM/WB stage.

Function
REQ-017 SHALL define access = i_mem_mem2reg OR i_mem_wmem.
REQ-018 SHALL implement a two-state FSM with states IDLE and BUS.
REQ-019 SHALL move from IDLE to BUS when access=1, and from BUS to IDLE in the cycle i_dbus_ack=1; all other conditions hold the current state.
REQ-020 SHALL, on the IDLE-to-BUS edge, latch the following into bus registers: o_dbus_addr = {i_mem_data[31:2], 2'b00}; o_dbus_we = i_mem_wmem; o_dbus_be = i_data_be for stores and 4'b1111 for loads; o_dbus_wdata aligned per REQ-021; plus byte offset, size and sign controls for the load.
REQ-021 SHALL form store data as {4{i_mem_dmem[7:0]}} when lsb=1, {2{i_mem_dmem[15:0]}} when lsh=1, and i_mem_dmem otherwise.
REQ-022 SHALL drive o_dbus_req = 1 exactly while in BUS; o_dbus_addr, o_dbus_we, o_dbus_be and o_dbus_wdata SHALL remain stable until ack.
REQ-023 SHALL compute o_mem_stall combinationally as (IDLE AND access) OR (BUS AND NOT i_dbus_ack); the stall falls in the ack cycle, so upstream advances on that edge.
REQ-024 SHALL, on each edge in IDLE with access=0, load MEM/WB with wreg = i_mem_wreg, rd = i_mem_rd and data = i_mem_data (1-cycle latency).
REQ-025 SHALL, on each edge in IDLE with access=1, and on each edge in BUS without ack, load MEM/WB with a bubble: wreg = 0, rd = 0, data = 0.
REQ-026 SHALL, on the ack edge, load MEM/WB with wreg = i_mem_wreg, rd = i_mem_rd, and data = the extracted load value for loads or i_mem_data for stores.
REQ-027 SHALL extract load values as follows:
  - byte: i_dbus_rdata[8*off+7 : 8*off], where off = latched addr[1:0];
  - half: i_dbus_rdata[16*off[1]+15 : 16*off[1]];
  - word: all 32 bits;
  - sub-word results are extended per the latched loadsignext.
REQ-028 SHALL ignore i_dbus_ack while in IDLE.
REQ-029 SHALL NOT check misalignment; addr[1:0] selects lanes only.
REQ-030 SHALL give a minimum access latency of 2 cycles, from access appearing to the MEM/WB load, when ack returns in the first BUS cycle.
REQ-031 SHALL, on consecutive accesses, return to IDLE for the cycle in which the next access is presented; at most one outstanding request is allowed.

Reset
REQ-032 SHALL, when i_reset=1 on a rising edge, force the state to IDLE and clear o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_wdata, o_wb_wreg, o_wb_rd, o_wb_data and all latched controls to 0, and set o_dbus_be to 4'b0000.
REQ-033 SHALL, when reset occurs in BUS, drop the request on that edge and discard any later ack; o_mem_stall then follows REQ-023 from IDLE.
REQ-034 SHALL give i_reset priority over every other input on the same edge.

Verification
REQ-035 SHALL cover ALU pass-through: wreg=1, rd=5, data=0x1234, access=0 -> next cycle o_wb_wreg=1, o_wb_rd=5, o_wb_data=0x1234, with o_mem_stall=0 throughout.
REQ-036 SHALL cover a signed byte load: addr=0x103, lsb=1, loadsignext=1, ack after 3 BUS cycles with rdata=0x80AABBCC -> o_dbus_addr=0x100, o_mem_stall high for 4 cycles, o_wb_data=0xFFFFFF80 with bubbles before it.
REQ-037 SHALL cover an unsigned halfword load: addr=0x22, lsh=1, loadsignext=0, rdata=0xBEEF1234 -> o_wb_data=0x0000BEEF.
REQ-038 SHALL cover a byte store: addr=0x41, dmem=0x000000A5, be=4'b0010 -> o_dbus_we=1, o_dbus_wdata=0xA5A5A5A5, o_dbus_be=4'b0010, and o_wb_wreg=0 after ack.
REQ-039 SHALL cover reset mid-access: i_reset=1 asserted in BUS, then ack pulsed -> o_dbus_req=0 on the next cycle, the ack is ignored, and o_wb_wreg=0.
REQ-040 SHALL cover back-to-back word load then store, each acked in 1 cycle: two independent bus transactions, o_dbus_req low for exactly one cycle between them, and correct MEM/WB values.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-bus transaction per load/store and
// holds the pipeline until it is acknowledged.
// It also aligns store data, extracts and extends load data, and registers
// the MEM/WB stage.
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_mem_*              EXE/MEM controls, destination reg, ALU result, store data
//   i_data_be            store byte enables
//   o_dbus_*             bus request, write strobe, address, write data, enables
//   i_dbus_ack/rdata     bus acknowledge and read data (valid in the ack cycle)
//   o_mem_stall          combinational stall of EXE/MEM and all earlier stages
//   o_wb_wreg/rd/data    registered MEM/WB stage
module mem_access_stage (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_mem2reg,
    input  logic        i_mem_wmem,
    input  logic        i_mem_wreg,
    input  logic        i_mem_loadsignext,
    input  logic        i_mem_lsb,
    input  logic        i_mem_lsh,
    input  logic [3:0]  i_data_be,
    input  logic [4:0]  i_mem_rd,
    input  logic [31:0] i_mem_data,
    input  logic [31:0] i_mem_dmem,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [31:0] o_dbus_addr,
    output logic [31:0] o_dbus_wdata,
    output logic [3:0]  o_dbus_be,
    input  logic        i_dbus_ack,
    input  logic [31:0] i_dbus_rdata,
    output logic        o_mem_stall,
    output logic        o_wb_wreg,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUS  = 1'b1;

    logic [0:0]  state;
    logic [0:0]  state_next;
    logic        access;
    logic [1:0]  lat_off;
    logic        lat_lsb;
    logic        lat_lsh;
    logic        lat_sext;
    logic        lat_load;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign access = i_mem_mem2reg | i_mem_wmem;

    // Next state and stall; ack is only honoured in BUS
    always_comb begin
        state_next  = state;
        o_mem_stall = 1'b0;
        if (state == IDLE) begin
            if (access) begin
                state_next  = BUS;
                o_mem_stall = 1'b1;
            end
        end else begin
            if (i_dbus_ack) begin
                state_next = IDLE;
            end else begin
                o_mem_stall = 1'b1;
            end
        end
    end

    // Replicate sub-word store data across all lanes; byte enables pick the lane
    always_comb begin
        store_data = i_mem_dmem;
        if (i_mem_lsb) begin
            store_data = {4{i_mem_dmem[7:0]}};
        end else if (i_mem_lsh) begin
            store_data = {2{i_mem_dmem[15:0]}};
        end
    end

    // Lane select and extension of load data using the latched controls
    always_comb begin
        ld_byte   = i_dbus_rdata[7:0];
        ld_half   = lat_off[1] ? i_dbus_rdata[31:16] : i_dbus_rdata[15:0];
        load_data = i_dbus_rdata;
        case (lat_off)
            2'd1:    ld_byte = i_dbus_rdata[15:8];
            2'd2:    ld_byte = i_dbus_rdata[23:16];
            2'd3:    ld_byte = i_dbus_rdata[31:24];
            default: ld_byte = i_dbus_rdata[7:0];
        endcase
        if (lat_lsb) begin
            load_data = {{24{lat_sext & ld_byte[7]}}, ld_byte};
        end else if (lat_lsh) begin
            load_data = {{16{lat_sext & ld_half[15]}}, ld_half};
        end
    end

    // State, bus registers and MEM/WB register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            o_dbus_req   <= 1'b0;
            o_dbus_we    <= 1'b0;
            o_dbus_addr  <= 32'd0;
            o_dbus_wdata <= 32'd0;
            o_dbus_be    <= 4'b0000;
            lat_off      <= 2'd0;
            lat_lsb      <= 1'b0;
            lat_lsh      <= 1'b0;
            lat_sext     <= 1'b0;
            lat_load     <= 1'b0;
            o_wb_wreg    <= 1'b0;
            o_wb_rd      <= 5'd0;
            o_wb_data    <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (access) begin
                    o_dbus_req   <= 1'b1;
                    o_dbus_we    <= i_mem_wmem;
                    o_dbus_addr  <= {i_mem_data[31:2], 2'b00};
                    o_dbus_wdata <= store_data;
                    o_dbus_be    <= i_mem_wmem ? i_data_be : 4'b1111;
                    lat_off      <= i_mem_data[1:0];
                    lat_lsb      <= i_mem_lsb;
                    lat_lsh      <= i_mem_lsh;
                    lat_sext     <= i_mem_loadsignext;
                    lat_load     <= i_mem_mem2reg;
                    o_wb_wreg    <= 1'b0;
                    o_wb_rd      <= 5'd0;
                    o_wb_data    <= 32'd0;
                end else begin
                    o_wb_wreg <= i_mem_wreg;
                    o_wb_rd   <= i_mem_rd;
                    o_wb_data <= i_mem_data;
                end
            end else begin
                if (i_dbus_ack) begin
                    o_dbus_req <= 1'b0;
                    o_wb_wreg  <= i_mem_wreg;
                    o_wb_rd    <= i_mem_rd;
                    o_wb_data  <= lat_load ? load_data : i_mem_data;
                end else begin
                    o_wb_wreg <= 1'b0;
                    o_wb_rd   <= 5'd0;
                    o_wb_data <= 32'd0;
                end
            end
        end
    end

endmodule
